// File: rtl/rtc_pkg.sv
// Shared types and default timing for the RTC multiplexed-bus sequencer.
package rtc_pkg;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DEF_T_SETUP = 2;
  localparam int unsigned DEF_T_PULSE = 8;
  localparam int unsigned DEF_T_HOLD  = 2;
  localparam int unsigned DEF_T_RECOV = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RECOV = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CYC_ADDR_WR = 2'd0,
    CYC_DATA_WR = 2'd1,
    CYC_DATA_RD = 2'd2
  } cyc_t;

  typedef struct packed {
    cyc_t              kind;
    logic [DATA_W-1:0] data;
  } req_t;

  function automatic logic is_write(cyc_t kind);
    return kind != CYC_DATA_RD;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter that times each bus phase; zero_c flags expiry.
module rtc_phase_timer
  import rtc_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (cnt != '0)      cnt <= cnt - CNT_W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// PicoBlaze-to-RTC bus-cycle sequencer (address write, data write, data read).
// Optional one-entry pending request queue enabled by defining RTC_PENDING_EN.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_PULSE = DEF_T_PULSE,
  parameter int unsigned T_HOLD  = DEF_T_HOLD,
  parameter int unsigned T_RECOV = DEF_T_RECOV
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              write_strobe,
  input  logic              read_strobe,
  input  logic              actRTC,
  input  logic              dir,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              rtc_cs_n,
  output logic              rtc_rd_n,
  output logic              rtc_wr_n,
  output logic              rtc_ad,
  output logic [DATA_W-1:0] rtc_bus_out,
  output logic              rtc_bus_oe,
  input  logic [DATA_W-1:0] rtc_bus_in
);

  state_t            state, state_next;
  req_t              cur, cur_next, new_req;
  logic              wr_req, rd_req, any_req, ovr_set;
  logic              load, zero_c;
  logic [CNT_W-1:0]  load_val;
  logic              cs_n_d, rd_n_d, wr_n_d, ad_d, oe_d, busy_d, done_d, rd_cap;
  logic [DATA_W-1:0] bus_d;
`ifdef RTC_PENDING_EN
  req_t              pend, pend_next;
  logic              pend_valid, pend_valid_next;
`endif

  // Request decode; a write wins over a simultaneous read.
  assign wr_req  = actRTC & write_strobe;
  assign rd_req  = actRTC & read_strobe & ~dir;
  assign any_req = wr_req | rd_req;
  assign new_req = '{kind: wr_req ? (dir ? CYC_ADDR_WR : CYC_DATA_WR) : CYC_DATA_RD,
                     data: wr_data};

  rtc_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .zero_c   (zero_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur        <= '{kind: CYC_ADDR_WR, data: '0};
`ifdef RTC_PENDING_EN
      pend       <= '{kind: CYC_ADDR_WR, data: '0};
      pend_valid <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      cur        <= cur_next;
`ifdef RTC_PENDING_EN
      pend       <= pend_next;
      pend_valid <= pend_valid_next;
`endif
    end
  end

  // Next state, latched request and timer reload.
  always_comb begin
    state_next = state;
    cur_next   = cur;
    ovr_set    = wr_req & rd_req;
`ifdef RTC_PENDING_EN
    pend_next       = pend;
    pend_valid_next = pend_valid;
`endif
    case (state)
      ST_IDLE:  if (any_req) begin
                  state_next = ST_SETUP;
                  cur_next   = new_req;
                end
      ST_SETUP: if (zero_c) state_next = ST_PULSE;
      ST_PULSE: if (zero_c) state_next = ST_HOLD;
      ST_HOLD:  if (zero_c) state_next = ST_RECOV;
      ST_RECOV: if (zero_c) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
`ifdef RTC_PENDING_EN
    // Queued (or just-arriving) request chains straight from RECOV into SETUP.
    if (state == ST_RECOV && zero_c && (pend_valid || any_req)) begin
      state_next      = ST_SETUP;
      cur_next        = pend_valid ? pend : new_req;
      pend_valid_next = pend_valid && any_req;
      if (pend_valid && any_req) pend_next = new_req;
    end else if (state != ST_IDLE && any_req) begin
      if (pend_valid) ovr_set = 1'b1;
      else begin
        pend_next       = new_req;
        pend_valid_next = 1'b1;
      end
    end
`else
    if (state != ST_IDLE && any_req) ovr_set = 1'b1;
`endif
    load     = (state_next != state);
    load_val = '0;
    case (state_next)
      ST_SETUP: load_val = CNT_W'(T_SETUP - 1);
      ST_PULSE: load_val = CNT_W'(T_PULSE - 1);
      ST_HOLD:  load_val = CNT_W'(T_HOLD - 1);
      ST_RECOV: load_val = CNT_W'(T_RECOV - 1);
      default:  load_val = '0;
    endcase
  end

  // Pin values for the upcoming state, so strobe-to-pin is one register deep.
  always_comb begin
    cs_n_d = 1'b1;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    ad_d   = 1'b1;
    oe_d   = 1'b0;
    bus_d  = '0;
    if (state_next == ST_SETUP || state_next == ST_PULSE || state_next == ST_HOLD) begin
      cs_n_d = 1'b0;
      ad_d   = (cur_next.kind != CYC_ADDR_WR);
      if (is_write(cur_next.kind)) begin
        oe_d  = 1'b1;
        bus_d = cur_next.data;
      end
    end
    if (state_next == ST_PULSE) begin
      if (is_write(cur_next.kind)) wr_n_d = 1'b0;
      else                         rd_n_d = 1'b0;
    end
    busy_d = (state_next != ST_IDLE);
    done_d = (state == ST_RECOV) && zero_c;
    rd_cap = (state == ST_PULSE) && zero_c && (cur.kind == CYC_DATA_RD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rtc_cs_n    <= 1'b1;
      rtc_rd_n    <= 1'b1;
      rtc_wr_n    <= 1'b1;
      rtc_ad      <= 1'b1;
      rtc_bus_oe  <= 1'b0;
      rtc_bus_out <= '0;
      rd_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rtc_cs_n    <= cs_n_d;
      rtc_rd_n    <= rd_n_d;
      rtc_wr_n    <= wr_n_d;
      rtc_ad      <= ad_d;
      rtc_bus_oe  <= oe_d;
      rtc_bus_out <= bus_d;
      busy        <= busy_d;
      done        <= done_d;
      if (ovr_set) overrun <= 1'b1;
      if (rd_cap)  rd_data <= rtc_bus_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: directed test-plan cases plus random traffic
// against a cycle-offset transaction model. Honours RTC_PENDING_EN when defined.
module tb_rtc_bus_ctrl;

  localparam int unsigned TS  = 2;
  localparam int unsigned TP  = 8;
  localparam int unsigned TH  = 2;
  localparam int unsigned TR  = 4;
  localparam int          LEN = int'(TS + TP + TH + TR);
  localparam int          K_PULSE = int'(TS);
  localparam int          K_HOLD  = int'(TS + TP);
  localparam int          K_RECOV = int'(TS + TP + TH);

  logic       clk = 1'b0;
  logic       reset_n;
  logic       write_strobe, read_strobe, actRTC, dir;
  logic [7:0] wr_data, rtc_bus_in;
  logic [7:0] rd_data, rtc_bus_out;
  logic       busy, done, overrun, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, rtc_bus_oe;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_k is the cycle offset inside the current bus cycle (-1 when idle).
  int         m_k, m_kind, m_pkind;
  logic [7:0] m_data, m_pdata, m_rd;
  bit         m_ovr, m_done, m_pv;

  rtc_bus_ctrl #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_RECOV(TR)) dut (
    .clk(clk), .reset_n(reset_n), .write_strobe(write_strobe), .read_strobe(read_strobe),
    .actRTC(actRTC), .dir(dir), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .done(done), .overrun(overrun), .rtc_cs_n(rtc_cs_n), .rtc_rd_n(rtc_rd_n),
    .rtc_wr_n(rtc_wr_n), .rtc_ad(rtc_ad), .rtc_bus_out(rtc_bus_out),
    .rtc_bus_oe(rtc_bus_oe), .rtc_bus_in(rtc_bus_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = -1; m_kind = 0; m_pkind = 0; m_data = 8'h00; m_pdata = 8'h00;
    m_rd = 8'h00; m_ovr = 1'b0; m_done = 1'b0; m_pv = 1'b0;
  endtask

  task automatic model_start(input int kind, input logic [7:0] data);
    m_k = 0; m_kind = kind; m_data = data;
  endtask

  // Advance the model across one rising edge given the inputs sampled there.
  task automatic model_edge(input bit ws, input bit rs, input bit act, input bit d,
                            input logic [7:0] data, input logic [7:0] bin);
    bit wr, rd, any;
    int kind;
    wr   = act && ws;
    rd   = act && rs && !d;
    any  = wr || rd;
    kind = wr ? (d ? 0 : 1) : 2;
    if (wr && rd) m_ovr = 1'b1;
    m_done = 1'b0;
    if (m_k == K_HOLD - 1 && m_kind == 2) m_rd = bin;
    if (m_k < 0) begin
      if (any) model_start(kind, data);
    end else if (m_k == LEN - 1) begin
      m_done = 1'b1;
      m_k    = -1;
`ifdef RTC_PENDING_EN
      if (m_pv) begin
        model_start(m_pkind, m_pdata);
        m_pv = 1'b0;
        if (any) begin m_pv = 1'b1; m_pkind = kind; m_pdata = data; end
      end else if (any) model_start(kind, data);
`else
      if (any) m_ovr = 1'b1;
`endif
    end else begin
      m_k++;
      if (any) begin
`ifdef RTC_PENDING_EN
        if (m_pv) m_ovr = 1'b1;
        else begin m_pv = 1'b1; m_pkind = kind; m_pdata = data; end
`else
        m_ovr = 1'b1;
`endif
      end
    end
  endtask

  task automatic check_all();
    bit act_ph, pulse, isw;
    act_ph = (m_k >= 0) && (m_k < K_RECOV);
    pulse  = (m_k >= K_PULSE) && (m_k < K_HOLD);
    isw    = (m_kind != 2);
    check("cs_n",    32'(rtc_cs_n),   32'(!act_ph));
    check("ad",      32'(rtc_ad),     32'(act_ph ? (m_kind != 0) : 1'b1));
    check("oe",      32'(rtc_bus_oe), 32'(act_ph && isw));
    check("wr_n",    32'(rtc_wr_n),   32'(!(pulse && isw)));
    check("rd_n",    32'(rtc_rd_n),   32'(!(pulse && !isw)));
    check("busy",    32'(busy),       32'(m_k >= 0));
    check("done",    32'(done),       32'(m_done));
    check("overrun", 32'(overrun),    32'(m_ovr));
    check("rd_data", 32'(rd_data),    32'(m_rd));
    if (act_ph && isw) check("bus_out", 32'(rtc_bus_out), 32'(m_data));
  endtask

  // One clock: drive inputs now (just after a falling edge), check at the next falling edge.
  task automatic cycle(input bit ws, input bit rs, input bit act, input bit d,
                       input logic [7:0] data, input logic [7:0] bin);
    write_strobe = ws; read_strobe = rs; actRTC = act; dir = d;
    wr_data = data; rtc_bus_in = bin;
    @(posedge clk);
    model_edge(ws, rs, act, d, data, bin);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("arst_bus_out", 32'(rtc_bus_out), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int cnt_a, cnt_b, cnt_c, first_cs, first_lo, done_at;

  initial begin
    reset_n = 1'b0;
    write_strobe = 1'b0; read_strobe = 1'b0; actRTC = 1'b0; dir = 1'b0;
    wr_data = 8'h00; rtc_bus_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("rst_bus_out", 32'(rtc_bus_out), 32'h0);
    reset_n = 1'b1;
    idle(2);

    // Read with dir=1 is ignored entirely.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h11);
    idle(3);
    check("rd_dir1_busy", 32'(busy), 32'h0);
    check("rd_dir1_ovr",  32'(overrun), 32'h0);

    // Address write of 8'h23.
    cnt_a = 0; cnt_b = 0; first_cs = -1; first_lo = -1; done_at = -1;
    for (int j = 0; j < 20; j++) begin
      if (j == 0) cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h23, 8'h00);
      else        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (!rtc_ad && rtc_bus_oe && rtc_bus_out == 8'h23) cnt_a++;
      if (!rtc_wr_n) begin cnt_b++; if (first_lo < 0) first_lo = j; end
      if (!rtc_cs_n && first_cs < 0) first_cs = j;
      if (done && done_at < 0) done_at = j;
    end
    check("aw_ad_bus_cycles", 32'(cnt_a), 32'd12);
    check("aw_wr_low_cycles", 32'(cnt_b), 32'd8);
    check("aw_wr_after_cs",   32'(first_lo - first_cs), 32'd2);
    check("aw_done_latency",  32'(done_at), 32'd16);

    // Data read of 8'h59; bus changes to 8'hAA once PULSE has ended.
    cnt_a = 0; cnt_b = 0; done_at = -1;
    for (int j = 0; j < 20; j++) begin
      if (j == 0)      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h59);
      else if (j < 11) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h59);
      else             cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hAA);
      if (!rtc_rd_n) cnt_a++;
      if (rtc_bus_oe) cnt_b++;
      if (done && done_at < 0) begin
        done_at = j;
        check("rd_data_at_done", 32'(rd_data), 32'h59);
      end
    end
    check("rd_low_cycles", 32'(cnt_a), 32'd8);
    check("rd_oe_cycles",  32'(cnt_b), 32'd0);
    check("rd_done_seen",  32'(done_at), 32'd16);

    // Second write five cycles into a busy cycle.
    cnt_a = 0;
    for (int j = 0; j < 40; j++) begin
      if (j == 0)      cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hA1, 8'h00);
      else if (j == 5) cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h00);
      else             cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (done) cnt_a++;
    end
`ifdef RTC_PENDING_EN
    check("b2b_done_count", 32'(cnt_a), 32'd2);
    check("b2b_overrun",    32'(overrun), 32'h0);
`else
    check("b2b_done_count", 32'(cnt_a), 32'd1);
    check("b2b_overrun",    32'(overrun), 32'h1);
`endif

    // Simultaneous write and read strobes: the data write runs, the read is lost.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h5C, 8'h00);
    check("sim_ad_data", 32'(rtc_ad), 32'h1);
    check("sim_oe",      32'(rtc_bus_oe), 32'h1);
    check("sim_overrun", 32'(overrun), 32'h1);
    idle(18);

    // Asynchronous reset during PULSE, then a normal cycle.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 8'h00);
    idle(4);
    check("pre_rst_wr_n", 32'(rtc_wr_n), 32'h0);
    async_reset();
    cnt_a = 0;
    for (int j = 0; j < 3; j++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (done) cnt_a++;
    end
    check("rst_no_done", 32'(cnt_a), 32'd0);
    cnt_a = 0;
    for (int j = 0; j < 20; j++) begin
      if (j == 0) cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h3E, 8'h00);
      else        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (done) cnt_a++;
    end
    check("post_rst_done", 32'(cnt_a), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit ws, rs;
      ws = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 7) == 0);
      cycle(ws, rs, ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom));
      if (i == 1500) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus-cycle sequencer between the PicoBlaze port interface and the external real-time clock's multiplexed address/data bus. It converts single-cycle `write_strobe`/`read_strobe` pulses qualified by `actRTC` and `dir` into properly timed RTC address-write, data-write and data-read cycles. It also captures read data for the `in_port` mux. It sits beside the port-ID decoder; firmware polls `busy` between accesses.

## Interface
Parameters:
- `T_SETUP`, 2: cycles with CS and A/D asserted before the RD/WR pulse (1..255)
- `T_PULSE`, 8: RD/WR low width in cycles (1..255)
- `T_HOLD`, 2: cycles after the RD/WR pulse with CS low and data driven (1..255)
- `T_RECOV`, 4: cycles with CS high before the next cycle may start (1..255)

Ports:
- `clk` in 1: system clock
- `reset_n` in 1: asynchronous, active-low reset
- `write_strobe` in 1: PicoBlaze output strobe (write or k_write, already ORed)
- `read_strobe` in 1: PicoBlaze input strobe
- `actRTC` in 1: decoder select for the RTC
- `dir` in 1: 1 = address phase, 0 = data phase
- `wr_data` in 8: `out_port`
- `rd_data` out 8: last byte read from the RTC
- `busy` out 1: bus cycle in progress
- `done` out 1: one-cycle pulse at the end of every cycle
- `overrun` out 1: sticky; a request was lost
- `rtc_cs_n`, `rtc_rd_n`, `rtc_wr_n` out 1: RTC controls, active-low
- `rtc_ad` out 1: A/D select (0 = address, 1 = data)
- `rtc_bus_out` out 8, `rtc_bus_oe` out 1, `rtc_bus_in` in 8: tristate split of the AD bus; the pad lives at top level

## Operation
- Request decode happens in any cycle.
  - `actRTC & write_strobe & dir` starts an address write.
  - `actRTC & write_strobe & !dir` starts a data write.
  - `actRTC & read_strobe & !dir` starts a data read.
  - `actRTC & read_strobe & dir` is ignored, with no flag.
- When `write_strobe` and `read_strobe` arrive together, the write is taken. The read is lost and sets `overrun`.
- At acceptance, `wr_data` and the cycle type are latched.
- The FSM runs IDLE→SETUP→PULSE→HOLD→RECOV→IDLE. An 8-bit down-counter is loaded with `T_x − 1` on entry to each state, and the state is left when the counter reads 0.
- Outputs by state:
  - SETUP: `rtc_cs_n`=0, `rtc_ad` set per type; for writes, `rtc_bus_oe`=1 and `rtc_bus_out`=latched byte.
  - PULSE: as SETUP, plus `rtc_wr_n`=0 (write) or `rtc_rd_n`=0 (read).
  - HOLD: as SETUP, with RD/WR high again.
  - RECOV: `rtc_cs_n`=1, `rtc_bus_oe`=0, `rtc_ad`=1.
- For reads, `rtc_bus_in` is registered into `rd_data` on the clock edge that ends the last PULSE cycle. `rd_data` holds that value until the next read.
- A request arriving while `busy` is dropped and sets `overrun`, except as provided under Configuration. `overrun` clears only on reset.
- Reset values: `rtc_cs_n`=`rtc_rd_n`=`rtc_wr_n`=`rtc_ad`=1; `rtc_bus_oe`=0; `rtc_bus_out`=0; `rd_data`=0; `busy`=`done`=`overrun`=0; state IDLE.
- Reset asserted mid-cycle forces these values immediately (asynchronously) and aborts the cycle. No `done` is produced.

## Timing
- A strobe sampled high at edge N moves the FSM to SETUP at edge N, so `busy` and `rtc_cs_n`=0 are visible in the cycle after N.
- Bus cycle length is exactly T_SETUP+T_PULSE+T_HOLD+T_RECOV cycles; the default is 16.
- `done` is high for one cycle, the first cycle back in IDLE. `busy` is low in that same cycle, and a new request may be accepted then.
- `rd_data` is valid from the cycle after PULSE ends. It is guaranteed valid when `done` is seen.
- Outputs are registered, with no combinational path from strobes to RTC pins.

## Configuration
- `RTC_PENDING_EN` defined:
  - A one-entry pending register (type plus byte) captures the first request that arrives while busy.
  - That request starts in place of IDLE: RECOV→SETUP directly, with `done` still pulsed for one cycle.
  - A second request while the entry is full sets `overrun`.
- Not defined: there is no pending register, and every request while busy sets `overrun`.

## Structure
- Shared package `rtc_pkg`:
  - state encoding (IDLE, SETUP, PULSE, HOLD, RECOV)
  - cycle-type encoding (ADDR_WR, DATA_WR, DATA_RD)
  - default timing constants
- One sub-module, `rtc_phase_timer`: the 8-bit loadable down-counter with a zero flag.
- The FSM and output registers stay in `rtc_bus_ctrl`.

## Test plan
- Address write: `dir`=1, `wr_data`=8'h23, one `write_strobe` pulse.
  - `rtc_ad`=0 and bus=8'h23 for 12 cycles.
  - `rtc_wr_n` low for 8 cycles, starting 2 cycles after `rtc_cs_n` falls.
  - `done` 16 cycles after the strobe.
- Data read: `rtc_bus_in`=8'h59, `dir`=0, one `read_strobe` pulse.
  - `rtc_rd_n` low for 8 cycles and `rtc_bus_oe`=0 throughout.
  - `rd_data`=8'h59 at `done`.
  - `rtc_bus_in` changed to 8'hAA during HOLD leaves `rd_data` at 8'h59.
- Simultaneous `write_strobe` and `read_strobe`: a data-write cycle runs and `overrun`=1.
- Second write 5 cycles into a busy cycle:
  - with `RTC_PENDING_EN`, it runs back-to-back with two `done` pulses and `overrun`=0;
  - without it, only one cycle runs and `overrun`=1.
- `reset_n` pulsed low during PULSE: all RTC controls return to 1 and `rtc_bus_oe` to 0 in the same cycle, with no `done`. A new request afterwards completes normally.
- `read_strobe` with `dir`=1 produces no bus activity and no flags.
